noc_fcu_credit_arb: RTL and testbench

// - Parametrised credit-based flow-control unit for one NoC router, NUM_PORTS ports (N,S,E,W,L at default).
// - Keeps a downstream credit counter per output port and arbitrates input requests per output, round-robin.
// - Grants an output only when it has a credit.
// - Sits between the input-port route computation (req_port_addr) and the crossbar select / output link.

---
 rtl/noc_fcu_pkg.sv | 8 +
 rtl/fcu_rr_arbiter.sv | 40 ++++
 rtl/noc_fcu_credit_arb.sv | 71 +++++++
 tb/tb_noc_fcu_credit_arb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_fcu_pkg.sv
// noc_fcu_pkg: shared port enumeration, default sizes and address/credit typedefs for the flow-control unit.
package noc_fcu_pkg;
    typedef enum logic [2:0] {NORTH = 3'd0, SOUTH, EAST, WEST, LOCAL} port_e;
    localparam int NUM_PORTS_DEF = 5;
    localparam int CREDIT_DEPTH_DEF = 4;
    typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_addr_t;
    typedef logic [$clog2(CREDIT_DEPTH_DEF+1)-1:0] credit_cnt_t;
endpackage

// File: rtl/fcu_rr_arbiter.sv
// fcu_rr_arbiter: round-robin pick of the first request at or after a registered pointer, gated by an enable.
module fcu_rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt,
    output logic         o_any
);
    localparam int PW = $clog2(N);
    logic [PW-1:0]  r_ptr;
    logic [2*N-1:0] w_dbl;
    logic [PW:0]    w_off;
    logic [PW:0]    w_sum;
    logic [PW-1:0]  w_win;
    logic           w_hit;
    always_comb begin
        w_dbl = {i_req, i_req} >> r_ptr;
        w_hit = 1'b0;
        w_off = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_hit && w_dbl[k]) begin
                w_hit = 1'b1;
                w_off = (PW+1)'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + w_off;
        w_win = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : w_sum[PW-1:0];
    end
    assign o_any = w_hit;
    assign o_gnt = (i_en && w_hit) ? (N'(1) << w_win) : '0;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_ptr <= '0;
        else if (i_en && w_hit)
            r_ptr <= (w_win == PW'(N-1)) ? '0 : w_win + PW'(1);
    end
endmodule

// File: rtl/noc_fcu_credit_arb.sv
// noc_fcu_credit_arb: per-output credit counters with round-robin input arbitration; grants only with credit.
module noc_fcu_credit_arb
    import noc_fcu_pkg::*;
#(
    parameter int NUM_PORTS    = NUM_PORTS_DEF,
    parameter int ADDR_W       = $clog2(NUM_PORTS),
    parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
    parameter int CNT_W        = $clog2(CREDIT_DEPTH+1),
    parameter bit ALLOW_UTURN  = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_PORTS-1:0]                req_valid_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_port_addr_i,
    input  logic [NUM_PORTS-1:0]                credit_en_i,
    output logic [NUM_PORTS-1:0]                grant_access_o,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_input_o,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]     credit_cnt_o,
    output logic                                err_overflow_o,
    output logic                                err_addr_o
);
    logic [NUM_PORTS-1:0][CNT_W-1:0]     r_cnt;
    logic                                r_err_ovf;
    logic                                r_err_addr;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0]                w_bad;
    logic [NUM_PORTS-1:0]                w_en;
    logic [NUM_PORTS-1:0]                w_any;
    logic [NUM_PORTS-1:0]                w_ovf;
    logic [NUM_PORTS-1:0][CNT_W:0]       w_next;
    always_comb begin
        w_req = '0;
        w_bad = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_bad[i] = req_valid_i[i] && (int'(req_port_addr_i[i]) >= NUM_PORTS);
            for (int p = 0; p < NUM_PORTS; p++)
                w_req[p][i] = req_valid_i[i] && (int'(req_port_addr_i[i]) == p) && (ALLOW_UTURN || p != i);
        end
    end
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
        // Reset gating keeps grants low while the counters sit at full during reset.
        assign w_en[p] = rst_n_i && (r_cnt[p] != '0);
        fcu_rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .i_req   (w_req[p]),
            .i_en    (w_en[p]),
            .o_gnt   (grant_input_o[p]),
            .o_any   (w_any[p])
        );
        assign grant_access_o[p] = w_any[p] && w_en[p];
        assign w_next[p] = {1'b0, r_cnt[p]} - (CNT_W+1)'(grant_access_o[p]) + (CNT_W+1)'(credit_en_i[p]);
        assign w_ovf[p]  = w_next[p] > (CNT_W+1)'(CREDIT_DEPTH);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int p = 0; p < NUM_PORTS; p++)
                r_cnt[p] <= CNT_W'(CREDIT_DEPTH);
            r_err_ovf  <= 1'b0;
            r_err_addr <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                r_cnt[p] <= w_ovf[p] ? CNT_W'(CREDIT_DEPTH) : w_next[p][CNT_W-1:0];
            r_err_ovf  <= r_err_ovf | (|w_ovf);
            r_err_addr <= r_err_addr | (|w_bad);
        end
    end
    assign credit_cnt_o   = r_cnt;
    assign err_overflow_o = r_err_ovf;
    assign err_addr_o     = r_err_addr;
endmodule

// File: tb/tb_noc_fcu_credit_arb.sv
// tb_noc_fcu_credit_arb: scoreboard bench with a reference model plus directed checks of the credit/arbitration scenarios.
module tb_noc_fcu_credit_arb;
    import noc_fcu_pkg::*;
    typedef struct packed {
        logic [4:0]      acc;
        logic [4:0][4:0] gi;
        logic [4:0][2:0] cnt;
        logic            ovf;
        logic            aerr;
    } exp_t;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      req_valid;
    logic [4:0][2:0] req_addr;
    logic [4:0]      credit_en;
    logic [4:0]      grant_access;
    logic [4:0][4:0] grant_input;
    logic [4:0][2:0] credit_cnt;
    logic            err_ovf;
    logic            err_addr;
    logic [4:0]      s_acc;
    logic [4:0][4:0] s_gi;
    logic [4:0][2:0] s_cnt;
    logic            s_ovf;
    logic            s_aerr;
    exp_t            q[$];
    int              m_cnt[5];
    int              m_ptr[5];
    bit              m_ovf;
    bit              m_aerr;
    int              n_chk = 0;
    int              n_fail = 0;
    always #5 clk = ~clk;
    noc_fcu_credit_arb dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .req_valid_i     (req_valid),
        .req_port_addr_i (req_addr),
        .credit_en_i     (credit_en),
        .grant_access_o  (grant_access),
        .grant_input_o   (grant_input),
        .credit_cnt_o    (credit_cnt),
        .err_overflow_o  (err_ovf),
        .err_addr_o      (err_addr)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic mreset();
        for (int p = 0; p < 5; p++) begin
            m_cnt[p] = 4;
            m_ptr[p] = 0;
        end
        m_ovf  = 0;
        m_aerr = 0;
    endtask
    task automatic clr();
        req_valid = '0;
        req_addr  = '0;
        credit_en = '0;
    endtask
    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cyc();
        exp_t e;
        exp_t g;
        int   win[5];
        int   nc;
        e = '0;
        for (int p = 0; p < 5; p++) begin
            win[p] = -1;
            for (int k = 0; k < 5; k++) begin
                int j;
                j = (m_ptr[p] + k) % 5;
                if (win[p] < 0 && req_valid[j] && int'(req_addr[j]) == p && p != j)
                    win[p] = j;
            end
            e.acc[p] = rst_n && win[p] >= 0 && m_cnt[p] > 0;
            if (e.acc[p])
                e.gi[p] = 5'(1 << win[p]);
            e.cnt[p] = 3'(m_cnt[p]);
        end
        e.ovf  = m_ovf;
        e.aerr = m_aerr;
        q.push_back(e);
        #1;
        s_acc  = grant_access;
        s_gi   = grant_input;
        s_cnt  = credit_cnt;
        s_ovf  = err_ovf;
        s_aerr = err_addr;
        g = q.pop_front();
        chk("sb_acc", 32'(s_acc), 32'(g.acc));
        chk("sb_gi", 32'(s_gi), 32'(g.gi));
        chk("sb_cnt", 32'(s_cnt), 32'(g.cnt));
        chk("sb_ovf", 32'(s_ovf), 32'(g.ovf));
        chk("sb_aerr", 32'(s_aerr), 32'(g.aerr));
        @(posedge clk);
        if (!rst_n) mreset();
        else begin
            for (int p = 0; p < 5; p++) begin
                nc = m_cnt[p] - int'(e.acc[p]) + int'(credit_en[p]);
                if (nc > 4) begin
                    nc = 4;
                    m_ovf = 1;
                end
                m_cnt[p] = nc;
                if (e.acc[p]) m_ptr[p] = (win[p] + 1) % 5;
                if (req_valid[p] && int'(req_addr[p]) >= 5) m_aerr = 1;
            end
        end
        @(negedge clk);
    endtask
    int wins[5] = '{1, 2, 8, 1, 2};
    initial begin
        rst_n = 1'b0;
        clr();
        mreset();
        @(negedge clk);
        cyc();
        chk("rst_cnt", 32'(s_cnt), 32'({5{3'd4}}));
        chk("rst_gnt", 32'(s_acc), 0);
        chk("rst_err", {s_ovf, s_aerr}, 0);
        rst_n = 1'b1;
        cyc();
        // Input 0 drains EAST's four credits.
        req_valid[0] = 1'b1;
        req_addr[0]  = 3'(EAST);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t1_acc", 32'(s_acc[2]), (k < 4) ? 1 : 0);
            chk("t1_gi", 32'(s_gi[2]), (k < 4) ? 1 : 0);
            chk("t1_cnt", 32'(s_cnt[2]), (k < 4) ? 4 - k : 0);
        end
        credit_en[2] = 1'b1;
        cyc();
        chk("t2_acc0", 32'(s_acc[2]), 0);
        credit_en[2] = 1'b0;
        cyc();
        chk("t2_cnt1", 32'(s_cnt[2]), 1);
        chk("t2_acc1", 32'(s_acc[2]), 1);
        cyc();
        chk("t2_cnt0", 32'(s_cnt[2]), 0);
        chk("t2_acc2", 32'(s_acc[2]), 0);
        clr();
        // Round robin on LOCAL with credits returned on every grant.
        req_valid = 5'b01011;
        req_addr[0] = 3'(LOCAL);
        req_addr[1] = 3'(LOCAL);
        req_addr[3] = 3'(LOCAL);
        credit_en[4] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t3_win", 32'(s_gi[4]), wins[k]);
            chk("t3_cnt", 32'(s_cnt[4]), 4);
        end
        clr();
        req_valid[0] = 1'b1;
        req_addr[0]  = 3'(SOUTH);
        cyc();
        cyc();
        credit_en[1] = 1'b1;
        cyc();
        chk("t4_pre", 32'(s_cnt[1]), 2);
        chk("t4_acc", 32'(s_acc[1]), 1);
        clr();
        cyc();
        chk("t4_cnt", 32'(s_cnt[1]), 2);
        req_valid[2] = 1'b1;
        req_addr[2]  = 3'd2;
        cyc();
        chk("uturn_gnt", 32'(s_acc), 0);
        clr();
        cyc();
        chk("uturn_err", 32'(s_aerr), 0);
        credit_en[3] = 1'b1;
        cyc();
        chk("ovf_pre", 32'(s_ovf), 0);
        clr();
        cyc();
        chk("ovf_set", 32'(s_ovf), 1);
        chk("ovf_cnt", 32'(s_cnt[3]), 4);
        repeat (10) cyc();
        chk("ovf_sticky", 32'(s_ovf), 1);
        req_valid[2] = 1'b1;
        req_addr[2]  = 3'd7;
        cyc();
        chk("addr_gnt", 32'(s_acc), 0);
        clr();
        cyc();
        chk("addr_err", 32'(s_aerr), 1);
        // Reset in the middle of a burst on EAST with one credit left.
        credit_en[2] = 1'b1;
        cyc();
        clr();
        req_valid = 5'b00011;
        req_addr[0] = 3'(EAST);
        req_addr[1] = 3'(EAST);
        #2;
        chk("mid_pre_acc", 32'(grant_access[2]), 1);
        chk("mid_pre_cnt", 32'(credit_cnt[2]), 1);
        rst_n = 1'b0;
        mreset();
        cyc();
        chk("mid_rst_gnt", 32'(s_acc), 0);
        chk("mid_rst_gi", 32'(s_gi), 0);
        chk("mid_rst_cnt", 32'(s_cnt[2]), 4);
        rst_n = 1'b1;
        cyc();
        chk("mid_ptr0", 32'(s_gi[2]), 1);
        chk("mid_err", {s_ovf, s_aerr}, 0);
        cyc();
        chk("mid_ptr1", 32'(s_gi[2]), 2);
        chk("mid_cnt", 32'(s_cnt[2]), 3);
        clr();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
